lives_hud_renderer: RTL and testbench

- Draws and maintains the lives indicator on the 160x120 VGA frame buffer.
- Shows a row of MAX_LIVES filled rectangular markers, one pixel per clock, through the vga_adapter plot interface.
- Owns the lives count: each lost life erases one marker, and `init` restores and redraws the full row.
- Successor to the fixed-glyph draw blocks: parametrised geometry and count, event-driven incremental erase, queued events.

---
 rtl/hud_pkg.sv | 19 +
 rtl/rect_scan.sv | 79 +++++++
 rtl/lives_hud_renderer.sv | 170 +++++++++++++++++
 tb/tb_lives_hud_renderer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hud_pkg.sv
// rtl/hud_pkg.sv - shared types and geometry helpers for the HUD renderers
package hud_pkg;

  localparam int COLOUR_W = 3;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAW_ALL = 2'd1,
    ERASE    = 2'd2
  } hud_state_e;

  // x of the top-left corner of marker m in a row starting at x0
  function automatic int marker_x(input int x0, input int pitch, input int m);
    return x0 + m * pitch;
  endfunction

endpackage

// File: rtl/rect_scan.sv
// rtl/rect_scan.sv - registered raster scanner emitting one pixel per clock over a W x H box
module rect_scan #(
  parameter int W = 4,
  parameter int H = 4,
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter logic [X_W-1:0] RST_X = '0,
  parameter logic [Y_W-1:0] RST_Y = '0
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           i_start,
  input  logic           i_abort,
  input  logic [X_W-1:0] i_ox,
  input  logic [Y_W-1:0] i_oy,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_valid,
  output logic           o_last
);

  localparam int PX_W = $clog2(W + 1);
  localparam int PY_W = $clog2(H + 1);

  logic [PX_W-1:0] r_px;
  logic [PY_W-1:0] r_py;
  logic [X_W-1:0]  r_ox;
  logic [Y_W-1:0]  r_oy;
  logic            r_active;

  logic [PX_W-1:0] w_cur_px;
  logic [PY_W-1:0] w_cur_py;
  logic [X_W-1:0]  w_base_x;
  logic [Y_W-1:0]  w_base_y;
  logic            w_emit;
  logic            w_end_col;
  logic            w_end_box;

  // start emits pixel (0,0) on the same edge, so a start in the cycle that
  // shows the previous last pixel chains boxes with no gap
  always_comb begin
    w_emit    = i_start || (r_active && !i_abort);
    w_cur_px  = i_start ? '0 : r_px;
    w_cur_py  = i_start ? '0 : r_py;
    w_base_x  = i_start ? i_ox : r_ox;
    w_base_y  = i_start ? i_oy : r_oy;
    w_end_col = (w_cur_px == PX_W'(W - 1));
    w_end_box = w_end_col && (w_cur_py == PY_W'(H - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_px     <= '0;
      r_py     <= '0;
      r_ox     <= RST_X;
      r_oy     <= RST_Y;
      r_active <= 1'b0;
      o_x      <= RST_X;
      o_y      <= RST_Y;
      o_valid  <= 1'b0;
      o_last   <= 1'b0;
    end else begin
      o_valid <= w_emit;
      o_last  <= w_emit && w_end_box;
      if (w_emit) begin
        o_x      <= w_base_x + X_W'(w_cur_px);
        o_y      <= w_base_y + Y_W'(w_cur_py);
        r_ox     <= w_base_x;
        r_oy     <= w_base_y;
        r_active <= !w_end_box;
        r_px     <= w_end_col ? '0 : w_cur_px + PX_W'(1);
        r_py     <= w_end_col ? w_cur_py + PY_W'(1) : w_cur_py;
      end else begin
        r_active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/lives_hud_renderer.sv
// rtl/lives_hud_renderer.sv - lives counter and marker row drawn/erased into the VGA frame buffer
module lives_hud_renderer
  import hud_pkg::*;
#(
  parameter int MAX_LIVES = 4,
  parameter int MARK_W = 4,
  parameter int MARK_H = 4,
  parameter int GAP = 2,
  parameter int X0 = 10,
  parameter int Y0 = 20,
  parameter logic [COLOUR_W-1:0] FG_COLOUR = 3'b111,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = 3'b000,
  parameter int X_W = 8,
  parameter int Y_W = 7,
  localparam int CNT_W = $clog2(MAX_LIVES + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                init,
  input  logic                lose_life,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic [CNT_W-1:0]    lives,
  output logic                game_over
);

  localparam logic [CNT_W-1:0] FULL      = CNT_W'(MAX_LIVES);
  localparam logic [CNT_W-1:0] LAST_MARK = CNT_W'(MAX_LIVES - 1);

  if (X0 + MAX_LIVES * (MARK_W + GAP) - GAP > SCREEN_W || Y0 + MARK_H > SCREEN_H) begin : g_bad_geometry
    $error("lives_hud_renderer: marker row does not fit on the screen");
  end

  hud_state_e          r_state;
  logic                r_armed;
  logic [CNT_W-1:0]    r_lives;
  logic [CNT_W-1:0]    r_drawn;
  logic [CNT_W-1:0]    r_lat;
  logic [CNT_W-1:0]    r_mark;
  logic [COLOUR_W-1:0] r_colour;

  logic                w_lose;
  logic [CNT_W-1:0]    w_lives_nxt;
  logic                w_start;
  logic [CNT_W-1:0]    w_mark;
  logic [COLOUR_W-1:0] w_col;
  logic [X_W-1:0]      w_ox;
  logic [Y_W-1:0]      w_oy;
  logic [X_W-1:0]      w_sc_x;
  logic [Y_W-1:0]      w_sc_y;
  logic                w_sc_valid;
  logic                w_sc_last;

  // decides which marker (if any) the scanner starts this cycle, and its colour
  always_comb begin
    w_lose      = lose_life && !init && (r_lives != '0);
    w_lives_nxt = init ? FULL : (w_lose ? r_lives - CNT_W'(1) : r_lives);
    w_start     = 1'b0;
    w_mark      = r_mark;
    w_col       = BG_COLOUR;
    if (init) begin
      w_start = 1'b1;
      w_mark  = '0;
      w_col   = FG_COLOUR;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_drawn > r_lives) begin
            w_start = 1'b1;
            w_mark  = r_drawn - CNT_W'(1);
          end
        end
        DRAW_ALL: begin
          if (r_armed) begin
            w_start = 1'b1;
            w_mark  = '0;
          end else if (w_sc_last && r_mark != LAST_MARK) begin
            w_start = 1'b1;
            w_mark  = r_mark + CNT_W'(1);
          end
          w_col = (w_mark < r_lat) ? FG_COLOUR : BG_COLOUR;
        end
        ERASE: begin
          // chain straight into the next erase when more losses are queued
          if (w_sc_last && (r_drawn - CNT_W'(1)) > w_lives_nxt) begin
            w_start = 1'b1;
            w_mark  = r_drawn - CNT_W'(2);
          end
        end
        default: ;
      endcase
    end
    w_ox = X_W'(marker_x(X0, MARK_W + GAP, int'(w_mark)));
    w_oy = Y_W'(Y0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= DRAW_ALL;
      r_armed  <= 1'b1;
      r_lives  <= FULL;
      r_drawn  <= '0;
      r_lat    <= FULL;
      r_mark   <= '0;
      r_colour <= BG_COLOUR;
    end else begin
      r_lives <= w_lives_nxt;
      r_armed <= 1'b0;
      if (w_start) begin
        r_mark   <= w_mark;
        r_colour <= w_col;
      end
      if (init) begin
        r_state <= DRAW_ALL;
        r_lat   <= FULL;
      end else begin
        case (r_state)
          IDLE: begin
            if (r_drawn > r_lives) r_state <= ERASE;
          end
          DRAW_ALL: begin
            if (!r_armed && w_sc_last && r_mark == LAST_MARK) begin
              r_drawn <= r_lat;
              r_state <= IDLE;
            end
          end
          ERASE: begin
            if (w_sc_last) begin
              r_drawn <= r_drawn - CNT_W'(1);
              if (!w_start) r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  rect_scan #(
    .W     (MARK_W),
    .H     (MARK_H),
    .X_W   (X_W),
    .Y_W   (Y_W),
    .RST_X (X_W'(X0)),
    .RST_Y (Y_W'(Y0))
  ) u_scan (
    .clk     (clk),
    .reset_n (reset_n),
    .i_start (w_start),
    .i_abort (init),
    .i_ox    (w_ox),
    .i_oy    (w_oy),
    .o_x     (w_sc_x),
    .o_y     (w_sc_y),
    .o_valid (w_sc_valid),
    .o_last  (w_sc_last)
  );

  assign x         = w_sc_x;
  assign y         = w_sc_y;
  assign plot      = w_sc_valid;
  assign colour    = r_colour;
  assign lives     = r_lives;
  assign busy      = (r_state != IDLE) || (r_drawn != r_lives);
  assign game_over = (r_lives == '0) && !busy;

endmodule

// File: tb/tb_lives_hud_renderer.sv
// tb/tb_lives_hud_renderer.sv - directed bench for lives_hud_renderer with default geometry
module tb_lives_hud_renderer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       init;
  logic       lose_life;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic [2:0] lives;
  logic       game_over;

  int checks = 0;
  int errors = 0;

  lives_hud_renderer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .init      (init),
    .lose_life (lose_life),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .busy      (busy),
    .lives     (lives),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // packed {busy, plot, x, y, colour} for pixel idx of marker m; markers are 6 px apart from x=10
  task automatic chk_pix(input string tag, input int m, input int idx, input logic [2:0] col);
    logic [7:0]  ex;
    logic [6:0]  ey;
    logic [31:0] exp;
    ex  = 8'(10 + m * 6 + idx % 4);
    ey  = 7'(20 + idx / 4);
    exp = {12'd0, 1'b1, 1'b1, ex, ey, col};
    chk($sformatf("%s_m%0d_p%0d", tag, m, idx), {12'd0, busy, plot, x, y, colour}, exp);
  endtask

  task automatic scan(input string tag, input int m, input logic [2:0] col, input int from, input int to);
    for (int i = from; i < to; i++) begin
      chk_pix(tag, m, i, col);
      step();
    end
  endtask

  task automatic draw_all(input string tag);
    for (int m = 0; m < 4; m++) scan(tag, m, 3'd7, 0, 16);
  endtask

  initial begin
    reset_n   = 1'b0;
    init      = 1'b0;
    lose_life = 1'b0;
    step();
    step();
    chk("rst_plot", 32'(plot), 0);
    chk("rst_xy", {17'd0, x, y}, {17'd0, 8'd10, 7'd20});
    chk("rst_colour", 32'(colour), 0);
    chk("rst_lives", 32'(lives), 4);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_game_over", 32'(game_over), 0);

    // reset release auto-draws the full row
    reset_n = 1'b1;
    step();
    chk("boot_first_x", 32'(x), 10);
    draw_all("boot");
    chk("boot_done_plot", 32'(plot), 0);
    chk("boot_done_busy", 32'(busy), 0);
    chk("boot_done_lives", 32'(lives), 4);
    chk("boot_done_go", 32'(game_over), 0);

    // single loss in IDLE erases marker 3 (x28..31)
    lose_life = 1'b1;
    step();
    lose_life = 1'b0;
    chk("lose1_lives", 32'(lives), 3);
    chk("lose1_gap_plot", 32'(plot), 0);
    step();
    chk("lose1_first_x", 32'(x), 28);
    scan("erase3", 3, 3'd0, 0, 16);
    chk("lose1_done_plot", 32'(plot), 0);
    chk("lose1_done_busy", 32'(busy), 0);

    // second loss, then a third one mid-erase: markers 2 and 1 back-to-back
    lose_life = 1'b1;
    step();
    lose_life = 1'b0;
    chk("lose2_lives", 32'(lives), 2);
    step();
    scan("erase2", 2, 3'd0, 0, 3);
    chk_pix("erase2", 2, 3, 3'd0);
    lose_life = 1'b1;
    step();
    lose_life = 1'b0;
    scan("erase2", 2, 3'd0, 4, 16);
    chk("lose3_lives", 32'(lives), 1);
    scan("erase1", 1, 3'd0, 0, 16);
    chk("lose3_done_plot", 32'(plot), 0);
    chk("lose3_done_busy", 32'(busy), 0);
    chk("lose3_done_lives", 32'(lives), 1);

    // fourth loss; a loss at zero lives is ignored
    lose_life = 1'b1;
    step();
    lose_life = 1'b0;
    chk("lose4_lives", 32'(lives), 0);
    chk("lose4_go_early", 32'(game_over), 0);
    step();
    scan("erase0", 0, 3'd0, 0, 5);
    chk_pix("erase0", 0, 5, 3'd0);
    lose_life = 1'b1;
    step();
    lose_life = 1'b0;
    scan("erase0", 0, 3'd0, 6, 16);
    chk("lose4_done_plot", 32'(plot), 0);
    chk("lose4_done_lives", 32'(lives), 0);
    chk("lose4_go", 32'(game_over), 1);
    lose_life = 1'b1;
    step();
    lose_life = 1'b0;
    chk("extra_lives", 32'(lives), 0);
    chk("extra_plot", 32'(plot), 0);
    step();
    chk("extra_plot2", 32'(plot), 0);
    chk("extra_go", 32'(game_over), 1);

    // init restores the row
    init = 1'b1;
    step();
    init = 1'b0;
    chk("init1_lives", 32'(lives), 4);
    draw_all("init1");
    chk("init1_done_busy", 32'(busy), 0);
    chk("init1_go", 32'(game_over), 0);

    // init with lose_life on the 5th pixel of an erase: init wins
    lose_life = 1'b1;
    step();
    lose_life = 1'b0;
    chk("pre_init_lives", 32'(lives), 3);
    step();
    scan("erase3b", 3, 3'd0, 0, 4);
    chk_pix("erase3b", 3, 4, 3'd0);
    init      = 1'b1;
    lose_life = 1'b1;
    step();
    init      = 1'b0;
    lose_life = 1'b0;
    chk("init2_lives", 32'(lives), 4);
    draw_all("init2");
    chk("init2_done_plot", 32'(plot), 0);
    chk("init2_done_busy", 32'(busy), 0);
    chk("init2_done_lives", 32'(lives), 4);

    // one-cycle reset in the middle of a redraw
    init = 1'b1;
    step();
    init = 1'b0;
    scan("redraw", 0, 3'd7, 0, 16);
    scan("redraw", 1, 3'd7, 0, 5);
    chk_pix("redraw", 1, 5, 3'd7);
    lose_life = 1'b1;
    step();
    lose_life = 1'b0;
    chk("mid_lives", 32'(lives), 3);
    chk_pix("redraw", 1, 6, 3'd7);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("rst2_plot", 32'(plot), 0);
    chk("rst2_lives", 32'(lives), 4);
    chk("rst2_busy", 32'(busy), 1);
    step();
    draw_all("rst2");
    chk("rst2_done_plot", 32'(plot), 0);
    chk("rst2_done_busy", 32'(busy), 0);
    chk("rst2_done_lives", 32'(lives), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
